// File: rtl/alu_logic_pkg.sv
`default_nettype none
// ============================================================================
// Module : alu_logic_pkg
// Brief  : Shared op codes, FSM encoding and configuration check for the
//          serial bitwise logic unit.
// Rev    : 1.0
// ============================================================================
package alu_logic_pkg;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;
    localparam logic [1:0] OP_NOR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic bit slice_cfg_ok(input int unsigned width, input int unsigned slice);
        return (slice != 0) && (slice <= width) && ((width % slice) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_logic_serial_if.sv
`default_nettype none
// ============================================================================
// Module : alu_logic_serial_if
// Brief  : Operand/result valid-ready bundle for the serial logic unit.
// Rev    : 1.0
// ============================================================================
interface alu_logic_serial_if #(
    parameter int WIDTH = 32
) ();

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             zero;

    modport master (
        output in_valid, op, A, B, out_ready,
        input  in_ready, out_valid, out, zero
    );

    modport slave (
        input  in_valid, op, A, B, out_ready,
        output in_ready, out_valid, out, zero
    );

endinterface
`default_nettype wire

// File: rtl/alu_logic_serial_slice.sv
`default_nettype none
// ============================================================================
// Module : logic_slice
// Brief  : Combinational SLICE-wide AND/OR/XOR/NOR gate array.
// Rev    : 1.0
// ============================================================================
module logic_slice
    import alu_logic_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  wire logic [1:0]       op,
    input  wire logic [SLICE-1:0] a,
    input  wire logic [SLICE-1:0] b,
    output logic      [SLICE-1:0] y
);

    always_comb begin
        y = '0;
        case (op)
            OP_AND: y = a & b;
            OP_OR:  y = a | b;
            OP_XOR: y = a ^ b;
            OP_NOR: y = ~(a | b);
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_logic_serial.sv
`default_nettype none
// ============================================================================
// Module : alu_logic_serial
// Brief  : Multi-cycle bitwise logic unit; one shared slice array processes
//          the operands SLICE bits per cycle, LSB slice first.
// Rev    : 1.0
// ============================================================================
module alu_logic_serial
    import alu_logic_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input wire logic          clk,
    input wire logic          reset,
    alu_logic_serial_if.slave bus
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

    generate
        if (!slice_cfg_ok(WIDTH, SLICE)) begin : g_cfg_check
            $error("alu_logic_serial: SLICE must be nonzero and divide WIDTH");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] out_q, out_d;

    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;
    logic [SLICE-1:0] y_slice;

    // Slice mux: the counter steers the captured operands into the one gate array
    assign a_slice = a_q[int'(cnt_q)*SLICE +: SLICE];
    assign b_slice = b_q[int'(cnt_q)*SLICE +: SLICE];

    logic_slice #(
        .SLICE (SLICE)
    ) u_slice (
        .op (op_q),
        .a  (a_slice),
        .b  (b_slice),
        .y  (y_slice)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    op_d    = bus.op;
                    out_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                out_d[int'(cnt_q)*SLICE +: SLICE] = y_slice;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            out_q   <= out_d;
        end
    end

    // Handshake flags decode straight from the state register
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.out       = out_q;
    assign bus.zero      = ~|out_q;

endmodule
`default_nettype wire

// File: doc/alu_logic_serial.md
Name: alu_logic_serial

Overview:
- Multi-cycle 32-bit bitwise logic unit for the ALU Logic group.
- Sits on the ALU operand/result interface as the sequenced counterpart to the single-cycle gate-level logic units.
- Accepts an operand pair and an op code through a valid/ready handshake and processes the operands SLICE bits per cycle, LSB slice first.
- Returns the WIDTH-bit result plus a zero flag through a second valid/ready handshake.
- Used where area matters more than latency: one SLICE-wide gate array is shared across all slices.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SLICE, 8, bits processed per cycle. Must divide WIDTH. NSLICE = WIDTH/SLICE.

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair and op are valid.
- in_ready  output  1  unit can accept a new operation.
- op  input  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
- A  input  WIDTH  first operand.
- B  input  WIDTH  second operand.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- out  output  WIDTH  result register.
- zero  output  1  high when out == 0; meaningful only while out_valid = 1.

Behaviour:
- Reset: clocked in on the rising edge while reset = 1 (synchronous, active-high). All outputs are registered.
  - State goes to IDLE.
  - in_ready = 1, out_valid = 0, out = 0, zero = 1.
  - Slice counter = 0. Captured operands and op = 0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On an edge with in_valid = 1: capture A, B and op; clear out to 0; counter = 0; go to RUN.
- RUN:
  - in_ready = 0, out_valid = 0.
  - Each edge writes out[cnt*SLICE +: SLICE] = f(op, A_slice, B_slice) and increments cnt.
  - When cnt == NSLICE-1 the slice is written, cnt returns to 0 and the state goes to DONE.
  - Inputs A, B and op are ignored in RUN; only the captured copies are used.
- DONE:
  - out_valid = 1; out and zero are held stable.
  - On an edge with out_ready = 1, go to IDLE; out_valid drops, out keeps its value.
- Latency: acceptance at edge k gives out_valid = 1 after edge k+NSLICE (4 cycles for default parameters).
  - Throughput is at most one operation per NSLICE+2 cycles with out_ready held high.
- No overlap: in_ready is 0 in both RUN and DONE.
  - in_valid and out_ready high in the same DONE cycle: only the result handshake completes.
  - The new operand pair is accepted on the next edge, from IDLE.
- zero: computed combinationally from the out register, or registered equivalently.
  - Must equal (out == 0) whenever out_valid = 1.
- NOR: defined per bit as ~(a|b); no carry and no width growth.
- Reset mid-operation, in RUN or DONE: the operation is discarded, with no out_valid pulse; reset values apply on the next cycle.
- Reset dominates in_valid and out_ready on the same edge.
- A SLICE that does not divide WIDTH is a configuration error, flagged by an elaboration-time check.

Decomposition:
- Shared package alu_logic_pkg holds:
  - op code constants OP_AND, OP_OR, OP_XOR, OP_NOR (2 bits);
  - the FSM state encoding IDLE/RUN/DONE;
  - a width-check function for WIDTH/SLICE.
- One sub-module, logic_slice: combinational, parameter SLICE, ports op, a, b, y.
  - Instantiated once and fed by a slice mux selected by the counter.
- The top level holds the FSM, the counter, the operand capture registers and the out register.

Test Plan:
1. Reset then idle: reset high 2 cycles, then low -> in_ready = 1, out_valid = 0, out = 0x00000000, zero = 1.
2. OR op:
   - Stimulus: A = 0xF0F0_0000, B = 0x0F0F_00FF, op = 01, in_valid for 1 cycle.
   - Response: out_valid rises exactly 4 cycles after acceptance; out = 0xFFFF_00FF; zero = 0; in_ready = 0 throughout.
3. XOR yielding zero:
   - Stimulus: A = B = 0xDEAD_BEEF, op = 10.
   - Response: out = 0x00000000, zero = 1.
   - Also NOR with A = 0xFFFF_FFFF, B = 0 -> out = 0, zero = 1.
4. Backpressure:
   - Stimulus: out_ready held low 5 cycles after out_valid; A, B and op toggled randomly meanwhile.
   - Response: out and zero are stable; in_ready = 0; one result is consumed when out_ready rises.
   - Also: in_valid with out_ready in DONE is not accepted until IDLE.
5. Reset mid-RUN:
   - Stimulus: AND of 0x1234_5678 and 0xFFFF_0000; reset asserted 2 cycles after acceptance.
   - Response: no out_valid pulse; next cycle out = 0, in_ready = 1.
   - A following AND of 0x1234_5678 and 0x0000_FFFF gives 0x0000_5678.
6. Back-to-back: 100 random ops with out_ready = 1 checked against the reference a&b, a|b, a^b, ~(a|b).
   - Response: every result is correct; acceptances are spaced exactly NSLICE+2 = 6 cycles.
